// File: rtl/lms_ctr_spi_slave.sv
// -----------------------------------------------------------------------------
// lms_ctr_spi_slave
//
// SPI responder for the lms_ctr CPU subsystem (far end of the fpga_spi master).
// SPI mode 0, MSB first. SCLK / SS_n / MOSI are asynchronous and are
// oversampled in the clk domain through SYNC_STAGES-deep synchronisers; the
// registered edge pulses derived from them drive a two-state frame FSM.
//
// Optional feature (compile-time macro LMS_SPI_SLV_EOP_EN):
//   adds the end-of-packet value register at address 6 and status/control
//   bit 9. Without the macro address 6 reads 0 and bit 9 is always 0.
//
// Parameters
//   DATA_WIDTH   bits per SPI word (1..16)
//   IDLE_WORD    word shifted out when the tx holding register is empty
//   SYNC_STAGES  flops per pin synchroniser (>= 2)
//
// Ports
//   clk, reset         system clock (rising edge), asynchronous active-high reset
//   spi_select         register-bus chip select
//   mem_addr[2:0]      register address: 0 rx, 1 tx, 2 status, 3 control, 6 EOP
//   read_n, write_n    one-cycle active-low strobes
//   data_from_cpu[15:0] write data
//   data_to_cpu[15:0]  registered read data, valid the cycle after the strobe
//   irq                registered OR of (status & control)
//   dataavailable      rx word waiting (RRDY)
//   readyfordata       tx holding register empty (TRDY)
//   SCLK, SS_n, MOSI   SPI pins from the master (asynchronous)
//   MISO, MISO_oe      SPI data out and its output enable
// -----------------------------------------------------------------------------
module lms_ctr_spi_slave #(
  parameter int          DATA_WIDTH  = 8,
  parameter logic [15:0] IDLE_WORD   = 16'h00FF,
  parameter int          SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        spi_select,
  input  logic [2:0]  mem_addr,
  input  logic        read_n,
  input  logic        write_n,
  input  logic [15:0] data_from_cpu,
  output logic [15:0] data_to_cpu,
  output logic        irq,
  output logic        dataavailable,
  output logic        readyfordata,
  input  logic        SCLK,
  input  logic        SS_n,
  input  logic        MOSI,
  output logic        MISO,
  output logic        MISO_oe
);

  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(W - 1);

`ifdef LMS_SPI_SLV_EOP_EN
  localparam logic [15:0] CTRL_MASK = 16'h03F8;
`else
  localparam logic [15:0] CTRL_MASK = 16'h01F8;
`endif

  // ---------------------------------------------------------------------------
  // Pin synchronisers. Each stage holds {SCLK, SS_n, MOSI}; SS_n resets high so
  // leaving reset never looks like the start of a frame.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic [2:0] stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_reg <= 3'b010;
          else       stage_reg <= {SCLK, SS_n, MOSI};
        end
      end else begin : g_rest
        always_ff @(posedge clk or posedge reset) begin
          if (reset) stage_reg <= 3'b010;
          else       stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  logic sclk_s, ssn_s, mosi_s;
  assign {sclk_s, ssn_s, mosi_s} = g_sync[SYNC_STAGES-1].stage_reg;

  // Edge pulses are registered, so a pin change becomes a pulse SYNC_STAGES+1
  // clocks later. MOSI gets the same extra flop so the sampled bit lines up
  // with the SCLK rise pulse.
  logic sclk_prev_reg, ssn_prev_reg;
  logic sclk_rise_reg, sclk_fall_reg, ss_fall_reg, ss_rise_reg;
  logic mosi_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_reg <= 1'b0;
      ssn_prev_reg  <= 1'b1;
      sclk_rise_reg <= 1'b0;
      sclk_fall_reg <= 1'b0;
      ss_fall_reg   <= 1'b0;
      ss_rise_reg   <= 1'b0;
      mosi_reg      <= 1'b0;
    end else begin
      sclk_prev_reg <= sclk_s;
      ssn_prev_reg  <= ssn_s;
      sclk_rise_reg <= sclk_s & ~sclk_prev_reg;
      sclk_fall_reg <= ~sclk_s & sclk_prev_reg;
      ss_fall_reg   <= ~ssn_s & ssn_prev_reg;
      ss_rise_reg   <= ssn_s & ~ssn_prev_reg;
      mosi_reg      <= mosi_s;
    end
  end

  // ---------------------------------------------------------------------------
  // Register bus decode
  // ---------------------------------------------------------------------------
  logic rd_stb, wr_stb, rx_rd, tx_wr, st_wr, ctl_wr;
  assign rd_stb = spi_select & ~read_n;
  assign wr_stb = spi_select & ~write_n;
  assign rx_rd  = rd_stb && (mem_addr == 3'd0);
  assign tx_wr  = wr_stb && (mem_addr == 3'd1);
  assign st_wr  = wr_stb && (mem_addr == 3'd2);
  assign ctl_wr = wr_stb && (mem_addr == 3'd3);

  // ---------------------------------------------------------------------------
  // Frame FSM
  // ---------------------------------------------------------------------------
  typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;
  state_t state_reg, state_next;

  logic           load_fire, shift_fire, rx_fire, frame_start, frame_abort;
  logic           word_done;
  logic           reload_pend_reg;
  logic [CNT_W-1:0] bitcnt_reg;
  logic [W-1:0]   rx_shift_reg, rx_hold_reg, rx_word;
  logic [W-1:0]   tx_shift_reg, tx_hold_reg;
  logic           primed_reg, primed_next, tx_accept;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next  = state_reg;
    load_fire   = 1'b0;
    shift_fire  = 1'b0;
    rx_fire     = 1'b0;
    frame_start = 1'b0;
    frame_abort = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (ss_fall_reg) begin
          state_next  = ST_ACTIVE;
          load_fire   = 1'b1;
          frame_start = 1'b1;
        end
      end
      ST_ACTIVE: begin
        // Deselect wins over any SCLK edge in the same cycle.
        if (ss_rise_reg) begin
          state_next  = ST_IDLE;
          frame_abort = 1'b1;
        end else begin
          rx_fire = sclk_rise_reg;
          if (sclk_fall_reg) begin
            if (reload_pend_reg) load_fire  = 1'b1;
            else                 shift_fire = 1'b1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign word_done = rx_fire && (bitcnt_reg == LAST_BIT);

  generate
    if (W == 1) begin : g_rx_w1
      assign rx_word = mosi_reg;
    end else begin : g_rx_wn
      assign rx_word = {rx_shift_reg[W-2:0], mosi_reg};
    end
  endgenerate

  // A tx write is taken when holding is empty, or when a load empties it in
  // the same cycle (the shift register gets the old word, holding the new).
  assign tx_accept   = tx_wr && (!primed_reg || load_fire);
  assign primed_next = tx_accept ? 1'b1 : (load_fire ? 1'b0 : primed_reg);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tx_shift_reg    <= '0;
      tx_hold_reg     <= '0;
      primed_reg      <= 1'b0;
      rx_shift_reg    <= '0;
      rx_hold_reg     <= '0;
      bitcnt_reg      <= '0;
      reload_pend_reg <= 1'b0;
    end else begin
      if (load_fire)
        tx_shift_reg <= primed_reg ? tx_hold_reg : IDLE_WORD[W-1:0];
      else if (shift_fire)
        tx_shift_reg <= tx_shift_reg << 1;

      if (tx_accept) tx_hold_reg <= data_from_cpu[W-1:0];
      primed_reg <= primed_next;

      if (frame_start || frame_abort) begin
        bitcnt_reg      <= '0;
        reload_pend_reg <= 1'b0;
        rx_shift_reg    <= '0;
      end else begin
        if (rx_fire) begin
          rx_shift_reg <= rx_word;
          bitcnt_reg   <= word_done ? '0 : bitcnt_reg + 1'b1;
        end
        if (word_done)      reload_pend_reg <= 1'b1;
        else if (load_fire) reload_pend_reg <= 1'b0;
      end

      if (word_done) rx_hold_reg <= rx_word;
    end
  end

  // ---------------------------------------------------------------------------
  // Status flags. Clears (status write, rx read) are applied first so that a
  // same-cycle event sets the flag again.
  // ---------------------------------------------------------------------------
  logic rrdy_reg, roe_reg, toe_reg, tue_reg;
  logic rrdy_next, roe_next, toe_next, tue_next;

  always_comb begin
    rrdy_next = (st_wr || rx_rd) ? 1'b0 : rrdy_reg;
    roe_next  = st_wr ? 1'b0 : roe_reg;
    toe_next  = st_wr ? 1'b0 : toe_reg;
    tue_next  = st_wr ? 1'b0 : tue_reg;
    if (word_done) begin
      rrdy_next = 1'b1;
      // A read landing on the completing cycle has consumed the old word.
      if (rrdy_reg && !rx_rd) roe_next = 1'b1;
    end
    if (tx_wr && !tx_accept)     toe_next = 1'b1;
    if (load_fire && !primed_reg) tue_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rrdy_reg <= 1'b0;
      roe_reg  <= 1'b0;
      toe_reg  <= 1'b0;
      tue_reg  <= 1'b0;
    end else begin
      rrdy_reg <= rrdy_next;
      roe_reg  <= roe_next;
      toe_reg  <= toe_next;
      tue_reg  <= tue_next;
    end
  end

  logic eop_bit;
  logic [15:0] eop_read;

`ifdef LMS_SPI_SLV_EOP_EN
  logic [W-1:0] eop_val_reg;
  logic         eop_reg, eop_next;

  always_comb begin
    eop_next = st_wr ? 1'b0 : eop_reg;
    if (word_done && (rx_word == eop_val_reg))            eop_next = 1'b1;
    if (tx_wr && (data_from_cpu[W-1:0] == eop_val_reg))   eop_next = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      eop_val_reg <= '0;
      eop_reg     <= 1'b0;
    end else begin
      if (wr_stb && (mem_addr == 3'd6)) eop_val_reg <= data_from_cpu[W-1:0];
      eop_reg <= eop_next;
    end
  end

  assign eop_bit = eop_reg;
  always_comb begin
    eop_read        = '0;
    eop_read[W-1:0] = eop_val_reg;
  end
`else
  assign eop_bit  = 1'b0;
  assign eop_read = '0;
`endif

  logic [15:0] status_word, rx_ext, rd_data;
  logic [15:0] ctrl_reg;
  logic        irq_reg;
  logic [15:0] data_to_cpu_reg;

  always_comb begin
    status_word    = '0;
    status_word[3] = roe_reg;
    status_word[4] = toe_reg;
    status_word[5] = tue_reg;
    status_word[6] = ~primed_reg;
    status_word[7] = rrdy_reg;
    status_word[8] = roe_reg | toe_reg | tue_reg;
    status_word[9] = eop_bit;
  end

  always_comb begin
    rx_ext        = '0;
    rx_ext[W-1:0] = rx_hold_reg;
  end

  always_comb begin
    rd_data = '0;
    case (mem_addr)
      3'd0:    rd_data = rx_ext;
      3'd2:    rd_data = status_word;
      3'd3:    rd_data = ctrl_reg;
      3'd6:    rd_data = eop_read;
      default: rd_data = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl_reg        <= '0;
      irq_reg         <= 1'b0;
      data_to_cpu_reg <= '0;
    end else begin
      if (ctl_wr) ctrl_reg <= data_from_cpu & CTRL_MASK;
      irq_reg <= |(status_word & ctrl_reg);
      if (rd_stb) data_to_cpu_reg <= rd_data;
    end
  end

  assign data_to_cpu   = data_to_cpu_reg;
  assign irq           = irq_reg;
  assign dataavailable = rrdy_reg;
  assign readyfordata  = ~primed_reg;
  assign MISO_oe       = (state_reg == ST_ACTIVE);
  assign MISO          = (state_reg == ST_ACTIVE) & tx_shift_reg[W-1];

endmodule

// File: tb/tb_lms_ctr_spi_slave.sv
// Bench for lms_ctr_spi_slave (DATA_WIDTH=8). A table of frame vectors with
// hand-derived results, two cycle-exact collision sequences, the EOP feature
// (or its absence), then random frames checked against a word-level model.
module tb_lms_ctr_spi_slave;

  logic        clk = 1'b0;
  logic        reset;
  logic        spi_select;
  logic [2:0]  mem_addr;
  logic        read_n, write_n;
  logic [15:0] data_from_cpu, data_to_cpu;
  logic        irq, dataavailable, readyfordata;
  logic        SCLK, SS_n, MOSI, MISO, MISO_oe;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef LMS_SPI_SLV_EOP_EN
  localparam logic [15:0] CTRL_MASK = 16'h03F8;
`else
  localparam logic [15:0] CTRL_MASK = 16'h01F8;
`endif

  always #5 clk = ~clk;

  lms_ctr_spi_slave dut (
    .clk(clk), .reset(reset), .spi_select(spi_select), .mem_addr(mem_addr),
    .read_n(read_n), .write_n(write_n), .data_from_cpu(data_from_cpu),
    .data_to_cpu(data_to_cpu), .irq(irq), .dataavailable(dataavailable),
    .readyfordata(readyfordata), .SCLK(SCLK), .SS_n(SS_n), .MOSI(MOSI),
    .MISO(MISO), .MISO_oe(MISO_oe)
  );

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; mem_addr = a; data_from_cpu = d; write_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; write_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    @(negedge clk);
    spi_select = 1'b1; mem_addr = a; read_n = 1'b0;
    @(negedge clk);
    spi_select = 1'b0; read_n = 1'b1;
    d = data_to_cpu;
  endtask

  // One SS_n-framed transfer at clk/8. Optional hook: a bus access placed on
  // exactly the clock the DUT acts on the rise of bit hook_bit.
  task automatic spi_frame(input logic [15:0] mosi_w, input int nbits,
                           input int hook_bit, input bit hook_rd,
                           output logic [15:0] miso_w, output bit oe_ok,
                           output logic [15:0] hook_data);
    miso_w = '0; oe_ok = 1'b1; hook_data = '0;
    @(negedge clk); SS_n = 1'b0;
    repeat (6) @(negedge clk);
    for (int i = 0; i < nbits; i++) begin
      MOSI = mosi_w[nbits-1-i];
      repeat (4) @(negedge clk);
      miso_w = {miso_w[14:0], MISO};
      if (MISO_oe !== 1'b1) oe_ok = 1'b0;
      SCLK = 1'b1;
      for (int j = 0; j < 4; j++) begin
        @(negedge clk);
        if (i == hook_bit && j == 2) begin
          spi_select = 1'b1;
          if (hook_rd) begin read_n = 1'b0; mem_addr = 3'd0; end
          else begin write_n = 1'b0; mem_addr = 3'd2; data_from_cpu = 16'h0; end
        end
        if (i == hook_bit && j == 3) begin
          spi_select = 1'b0; read_n = 1'b1; write_n = 1'b1;
          hook_data = data_to_cpu;
        end
      end
      SCLK = 1'b0;
    end
    repeat (4) @(negedge clk);
    MOSI = 1'b0; SS_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  // ---------------- word-level reference model ----------------
  bit          m_hold_valid, m_rrdy, m_roe, m_toe, m_tue, m_eop;
  logic [7:0]  m_hold, m_rx, m_eop_val;
  logic [15:0] m_ctrl;

  function automatic logic [15:0] m_status();
    logic [15:0] s;
    s = '0;
    s[3] = m_roe; s[4] = m_toe; s[5] = m_tue; s[6] = !m_hold_valid;
    s[7] = m_rrdy; s[8] = m_roe | m_toe | m_tue;
`ifdef LMS_SPI_SLV_EOP_EN
    s[9] = m_eop;
`endif
    return s;
  endfunction

  task automatic m_load(output logic [7:0] cur);
    if (m_hold_valid) begin cur = m_hold; m_hold_valid = 1'b0; end
    else begin cur = 8'hFF; m_tue = 1'b1; end
  endtask

  task automatic m_tx_write(input logic [7:0] v);
    if (v == m_eop_val) m_eop = 1'b1;
    if (!m_hold_valid) begin m_hold = v; m_hold_valid = 1'b1; end
    else m_toe = 1'b1;
  endtask

  task automatic m_frame(input logic [15:0] mosi_w, input int nbits, output logic [15:0] exp_miso);
    logic [7:0] cur, w;
    exp_miso = '0; w = '0;
    m_load(cur);
    for (int i = 0; i < nbits; i++) begin
      exp_miso = {exp_miso[14:0], cur[7 - (i % 8)]};
      w = {w[6:0], mosi_w[nbits-1-i]};
      if (i % 8 == 7) begin
        if (m_rrdy) m_roe = 1'b1;
        m_rrdy = 1'b1;
        m_rx = w;
        if (w == m_eop_val) m_eop = 1'b1;
        m_load(cur);
      end
    end
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [15:0] ctrl;
    bit          tx1;
    logic [7:0]  tx1_val;
    bit          tx2;
    logic [7:0]  tx2_val;
    logic [15:0] mosi;
    int          nbits;
    logic [15:0] exp_miso;
    logic [15:0] exp_status;
    logic [15:0] exp_rx;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [8];

  initial begin
    logic [15:0] d, miso_w, hook_d, exp_m, rm;
    bit oe_ok;
    int nb;

    vecs[0] = '{16'h0000, 1'b1, 8'h3C, 1'b0, 8'h00, 16'h00A5,  8, 16'h003C, 16'h01E0, 16'h00A5, 1'b0};
    vecs[1] = '{16'h0008, 1'b0, 8'h00, 1'b0, 8'h00, 16'h1122, 16, 16'hFFFF, 16'h01E8, 16'h0022, 1'b1};
    vecs[2] = '{16'h0100, 1'b0, 8'h00, 1'b0, 8'h00, 16'h003C,  8, 16'h00FF, 16'h01E0, 16'h003C, 1'b1};
    vecs[3] = '{16'h0040, 1'b1, 8'h81, 1'b1, 8'h42, 16'h0096,  8, 16'h0081, 16'h01F0, 16'h0096, 1'b1};
    vecs[4] = '{16'h0020, 1'b1, 8'hC3, 1'b0, 8'h00, 16'h000A,  4, 16'h000C, 16'h0040, 16'h0096, 1'b0};
    vecs[5] = '{16'h0000, 1'b1, 8'h6B, 1'b0, 8'h00, 16'h005A,  8, 16'h006B, 16'h01E0, 16'h005A, 1'b0};
    vecs[6] = '{16'h0080, 1'b1, 8'hE7, 1'b0, 8'h00, 16'h000F,  8, 16'h00E7, 16'h01E0, 16'h000F, 1'b1};
    vecs[7] = '{16'h0010, 1'b1, 8'h12, 1'b0, 8'h00, 16'hFF01, 16, 16'h12FF, 16'h01E8, 16'h0001, 1'b0};

    reset = 1'b1; spi_select = 1'b0; mem_addr = '0; read_n = 1'b1; write_n = 1'b1;
    data_from_cpu = '0; SCLK = 1'b0; SS_n = 1'b1; MOSI = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_data_to_cpu", data_to_cpu, 16'h0);
    check("rst_irq", {15'h0, irq}, 16'h0);
    check("rst_miso", {15'h0, MISO}, 16'h0);
    check("rst_miso_oe", {15'h0, MISO_oe}, 16'h0);
    check("rst_rrdy", {15'h0, dataavailable}, 16'h0);
    check("rst_trdy", {15'h0, readyfordata}, 16'h1);
    bus_rd(3'd2, d); check("rst_status", d, 16'h0040);
    bus_rd(3'd3, d); check("rst_control", d, 16'h0000);
    bus_rd(3'd0, d); check("rst_rx", d, 16'h0000);
    bus_rd(3'd6, d); check("rst_addr6", d, 16'h0000);
    bus_rd(3'd7, d); check("rst_addr7", d, 16'h0000);

    // Table-driven frames (T1..T4)
    for (int v = 0; v < 8; v++) begin
      bus_wr(3'd3, vecs[v].ctrl);
      if (vecs[v].tx1) bus_wr(3'd1, {8'h00, vecs[v].tx1_val});
      if (vecs[v].tx2) bus_wr(3'd1, {8'h00, vecs[v].tx2_val});
      spi_frame(vecs[v].mosi, vecs[v].nbits, -1, 1'b0, miso_w, oe_ok, hook_d);
      check($sformatf("vec%0d_miso", v), miso_w, vecs[v].exp_miso);
      check($sformatf("vec%0d_oe_during", v), {15'h0, oe_ok}, 16'h1);
      check($sformatf("vec%0d_oe_after", v), {15'h0, MISO_oe}, 16'h0);
      check($sformatf("vec%0d_irq", v), {15'h0, irq}, {15'h0, vecs[v].exp_irq});
      bus_rd(3'd2, d); check($sformatf("vec%0d_status", v), d, vecs[v].exp_status);
      bus_rd(3'd0, d); check($sformatf("vec%0d_rx", v), d, vecs[v].exp_rx);
      bus_wr(3'd2, 16'h0);
    end
    bus_wr(3'd3, 16'h0);

    // T5: status write on the word-completion cycle, then a lone status write
    bus_rd(3'd0, d);
    bus_wr(3'd2, 16'h0);
    bus_wr(3'd1, 16'h0055);
    bus_wr(3'd1, 16'h0066);
    bus_rd(3'd2, d); check("t5_toe_set", d, 16'h0110);
    spi_frame(16'h003C, 8, 7, 1'b0, miso_w, oe_ok, hook_d);
    check("t5_miso", miso_w, 16'h0055);
    bus_rd(3'd2, d); check("t5_status_event_wins", d, 16'h01E0);
    bus_wr(3'd2, 16'h0);
    bus_rd(3'd2, d); check("t5_status_cleared", d, 16'h0040);
    bus_rd(3'd0, d); check("t5_rx", d, 16'h003C);

    // Rx read on the completion cycle while RRDY=1: no ROE, RRDY stays set
    spi_frame(16'h0081, 8, -1, 1'b0, miso_w, oe_ok, hook_d);
    bus_rd(3'd2, d); check("col_status_pre", d, 16'h01E0);
    spi_frame(16'h0024, 8, 7, 1'b1, miso_w, oe_ok, hook_d);
    check("col_read_old_word", hook_d, 16'h0081);
    bus_rd(3'd2, d); check("col_status_post", d, 16'h01E0);
    bus_rd(3'd0, d); check("col_rx", d, 16'h0024);
    bus_wr(3'd2, 16'h0);

    // T6: EOP register (or its absence)
    bus_wr(3'd3, 16'hFFFF);
    bus_rd(3'd3, d); check("ctrl_readback", d, CTRL_MASK);
    bus_wr(3'd3, 16'h0);
`ifdef LMS_SPI_SLV_EOP_EN
    bus_wr(3'd6, 16'h007E);
    bus_wr(3'd3, 16'h0200);
    spi_frame(16'h007E, 8, -1, 1'b0, miso_w, oe_ok, hook_d);
    check("t6_irq", {15'h0, irq}, 16'h1);
    bus_rd(3'd2, d); check("t6_status_eop", d, 16'h03E0);
    bus_rd(3'd6, d); check("t6_eop_value", d, 16'h007E);
    bus_wr(3'd3, 16'h0);
    m_rx = 8'h7E; m_eop_val = 8'h7E;
`else
    bus_wr(3'd6, 16'h007E);
    bus_rd(3'd6, d); check("t6_addr6_reads0", d, 16'h0000);
    m_rx = 8'h24; m_eop_val = 8'h00;
`endif
    bus_rd(3'd0, d);
    bus_wr(3'd2, 16'h0);

    // Random frames against the model
    m_hold_valid = 1'b0; m_rrdy = 1'b0; m_roe = 1'b0; m_toe = 1'b0;
    m_tue = 1'b0; m_eop = 1'b0; m_hold = '0;
    for (int it = 0; it < 40; it++) begin
      m_ctrl = 16'($urandom) & CTRL_MASK;
      bus_wr(3'd3, m_ctrl | (16'($urandom) & ~CTRL_MASK));
      if ($urandom_range(2, 0) != 0) begin
        rm = 16'($urandom);
        bus_wr(3'd1, rm);
        m_tx_write(rm[7:0]);
      end
      if ($urandom_range(3, 0) == 0) begin
        rm = 16'($urandom);
        bus_wr(3'd1, rm);
        m_tx_write(rm[7:0]);
      end
      rm = 16'($urandom);
      nb = int'($urandom_range(16, 1));
      m_frame(rm, nb, exp_m);
      spi_frame(rm, nb, -1, 1'b0, miso_w, oe_ok, hook_d);
      check($sformatf("rnd%0d_miso(n=%0d)", it, nb), miso_w, exp_m);
      check($sformatf("rnd%0d_irq", it), {15'h0, irq}, {15'h0, |(m_status() & m_ctrl)});
      check($sformatf("rnd%0d_rrdy_pin", it), {15'h0, dataavailable}, {15'h0, m_rrdy});
      check($sformatf("rnd%0d_trdy_pin", it), {15'h0, readyfordata}, {15'h0, !m_hold_valid});
      bus_rd(3'd2, d); check($sformatf("rnd%0d_status", it), d, m_status());
      if ($urandom_range(1, 0) == 1) begin
        bus_rd(3'd0, d); check($sformatf("rnd%0d_rx", it), d, {8'h00, m_rx});
        m_rrdy = 1'b0;
      end
      if ($urandom_range(2, 0) == 0) begin
        bus_wr(3'd2, 16'h0);
        m_roe = 1'b0; m_toe = 1'b0; m_tue = 1'b0; m_rrdy = 1'b0; m_eop = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
